// File: rtl/game_pkg.sv
// Shared types and defaults for the game sequencer and the screen multiplexer.
package game_pkg;

   typedef enum logic [1:0] {
      START       = 2'd0,
      GAME        = 2'd1,
      PLAYER1_WIN = 2'd2,
      PLAYER2_WIN = 2'd3
   } game_mode_t;

   localparam int WIN_HOLD_FRAMES_DEF       = 180;
   localparam int START_DEBOUNCE_FRAMES_DEF = 4;

endpackage

// File: rtl/game_mode_ctrl_frame_tick_gen.sv
// Rising-edge detector on vblnk; one combinational tick per frame.
module frame_tick_gen (
   input  logic clk,
   input  logic rst,
   input  logic vblnk,
   output logic frame_tick
);

   logic vblnk_prev;

   // Reset high so a vblnk already high at reset release does not tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) vblnk_prev <= 1'b1;
      else     vblnk_prev <= vblnk;
   end

   assign frame_tick = vblnk & ~vblnk_prev;

endmodule

// File: rtl/game_mode_ctrl.sv
// Game sequencer: frame-aligned screen select, start debounce/arming,
// hit latching and win-screen timing.
//
// state       | meaning
// START       | title screen, waiting for an armed, debounced start press
// GAME        | round in progress, latching player hits
// PLAYER1_WIN | player 1 win screen, held WIN_HOLD_FRAMES frames
// PLAYER2_WIN | player 2 win screen, held WIN_HOLD_FRAMES frames
module game_mode_ctrl
   import game_pkg::*;
#(
   parameter int WIN_HOLD_FRAMES       = WIN_HOLD_FRAMES_DEF,
   parameter int START_DEBOUNCE_FRAMES = START_DEBOUNCE_FRAMES_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       vblnk,
   input  logic       start_btn,
   input  logic       p1_hit,
   input  logic       p2_hit,
   output game_mode_t game_mode,
   output logic       map_init,
   output logic       round_active
);

   localparam int HW = $clog2(WIN_HOLD_FRAMES + 1);
   localparam int DW = $clog2(START_DEBOUNCE_FRAMES + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(WIN_HOLD_FRAMES - 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(START_DEBOUNCE_FRAMES - 1);
   localparam logic [DW-1:0] DEB_MAX   = DW'(START_DEBOUNCE_FRAMES);

   logic          frame_tick;
   game_mode_t    mode_nxt;
   logic          map_init_nxt;
   logic          h1, h2, h1_nxt, h2_nxt;
   logic          armed, armed_nxt;
   logic [DW-1:0] deb_cnt, deb_nxt;
   logic [HW-1:0] hold_cnt, hold_nxt;

   frame_tick_gen u_frame_tick (
      .clk        (clk),
      .rst        (rst),
      .vblnk      (vblnk),
      .frame_tick (frame_tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         game_mode    <= START;
         map_init     <= 1'b0;
         round_active <= 1'b0;
         h1           <= 1'b0;
         h2           <= 1'b0;
         armed        <= 1'b0;
         deb_cnt      <= '0;
         hold_cnt     <= '0;
      end else begin
         game_mode    <= mode_nxt;
         map_init     <= map_init_nxt;
         round_active <= (mode_nxt == GAME);
         h1           <= h1_nxt;
         h2           <= h2_nxt;
         armed        <= armed_nxt;
         deb_cnt      <= deb_nxt;
         hold_cnt     <= hold_nxt;
      end
   end

   always_comb begin
      mode_nxt     = game_mode;
      map_init_nxt = 1'b0;
      h1_nxt       = 1'b0;
      h2_nxt       = 1'b0;
      armed_nxt    = armed;
      deb_nxt      = deb_cnt;
      hold_nxt     = hold_cnt;

      case (game_mode)
         START: begin
            hold_nxt = '0;
            if (frame_tick) begin
               if (!start_btn) begin
                  armed_nxt = 1'b1;
                  deb_nxt   = '0;
               end else if (armed) begin
                  if (deb_cnt == DEB_LAST) begin
                     mode_nxt     = GAME;
                     map_init_nxt = 1'b1;
                     deb_nxt      = '0;
                     armed_nxt    = 1'b0;
                  end else if (deb_cnt != DEB_MAX) begin
                     deb_nxt = deb_cnt + 1'b1;
                  end
               end else begin
                  deb_nxt = '0;
               end
            end
         end

         GAME: begin
            // Hits landing in the tick cycle count toward this tick's decision.
            h1_nxt    = h1 | p1_hit;
            h2_nxt    = h2 | p2_hit;
            armed_nxt = 1'b0;
            deb_nxt   = '0;
            hold_nxt  = '0;
            if (frame_tick) begin
               case ({h1_nxt, h2_nxt})
                  2'b10:   mode_nxt = PLAYER2_WIN;
                  2'b01:   mode_nxt = PLAYER1_WIN;
                  2'b11:   mode_nxt = START;
                  default: mode_nxt = GAME;
               endcase
               if (h1_nxt || h2_nxt) begin
                  h1_nxt = 1'b0;
                  h2_nxt = 1'b0;
               end
            end
         end

         PLAYER1_WIN, PLAYER2_WIN: begin
            armed_nxt = 1'b0;
            deb_nxt   = '0;
            if (frame_tick) begin
               if (hold_cnt == HOLD_LAST) begin
                  mode_nxt = START;
                  hold_nxt = '0;
               end else begin
                  hold_nxt = hold_cnt + 1'b1;
               end
            end
         end

         default: begin
            mode_nxt  = START;
            armed_nxt = 1'b0;
            deb_nxt   = '0;
            hold_nxt  = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_game_mode_ctrl.sv
// Scenario bench for game_mode_ctrl with a per-frame expected/observed scoreboard.
module tb_game_mode_ctrl;
   import game_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       vblnk;
   logic       start_btn;
   logic       p1_hit;
   logic       p2_hit;
   game_mode_t game_mode;
   logic       map_init;
   logic       round_active;

   typedef struct {
      game_mode_t mode;
      logic       init;
   } exp_t;

   typedef struct {
      game_mode_t mode;
      int         init_cnt;
      logic       init_at_tick;
      int         glitch;
      int         bad_ra;
   } obs_t;

   exp_t       exp_q[$];
   obs_t       obs_q[$];
   game_mode_t last_mode;
   int         n_checks = 0;
   int         n_fail   = 0;

   game_mode_ctrl #(
      .WIN_HOLD_FRAMES       (3),
      .START_DEBOUNCE_FRAMES (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .vblnk        (vblnk),
      .start_btn    (start_btn),
      .p1_hit       (p1_hit),
      .p2_hit       (p2_hit),
      .game_mode    (game_mode),
      .map_init     (map_init),
      .round_active (round_active)
   );

   always #5 clk = ~clk;

   // One 20-clock frame, vblnk high on clocks 15..19; the tick edge is clock 15,
   // so its result is visible at the sample taken before clock 16.
   task automatic frame(input logic btn, input int p1c, input int p2c,
                        input game_mode_t em, input logic ei);
      exp_t e;
      obs_t o;
      e.mode = em;
      e.init = ei;
      exp_q.push_back(e);
      o.mode = START;
      o.init_cnt = 0;
      o.init_at_tick = 1'b0;
      o.glitch = 0;
      o.bad_ra = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (c != 16 && game_mode !== last_mode) o.glitch++;
         if (c == 16) o.mode = game_mode;
         if (map_init === 1'b1) begin
            o.init_cnt++;
            if (c == 16) o.init_at_tick = 1'b1;
         end
         if (round_active !== (game_mode == GAME)) o.bad_ra++;
         last_mode = game_mode;
         vblnk     = (c >= 15);
         start_btn = btn;
         p1_hit    = (c == p1c);
         p2_hit    = (c == p2c);
      end
      obs_q.push_back(o);
   endtask

   task automatic test_reset;
      rst = 1'b1; vblnk = 1'b1; start_btn = 1'b0; p1_hit = 1'b0; p2_hit = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (game_mode !== START || map_init !== 1'b0 || round_active !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got mode=%0d init=%b ra=%b required mode=0 init=0 ra=0",
                  game_mode, map_init, round_active);
      end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++;
         if (dut.frame_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_tick clk %0d: got %b required 0", i, dut.frame_tick);
         end
         @(negedge clk);
      end
      n_checks++;
      if (game_mode !== START || map_init !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: got mode=%0d init=%b required mode=0 init=0",
                  game_mode, map_init);
      end
      last_mode = START;
   endtask

   task automatic test_armed_start;
      exp_t e;
      obs_t o;
      int fr = 0;
      frame(1'b0, -1, -1, START, 1'b0);
      frame(1'b1,  5, -1, START, 1'b0);
      frame(1'b1, -1, -1, GAME,  1'b1);
      frame(1'b0, -1, -1, GAME,  1'b0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); fr++;
         n_checks++;
         if (o.mode !== e.mode) begin n_fail++;
            $display("FAIL armed_start mode f%0d: got %s required %s", fr, o.mode.name(), e.mode.name()); end
         n_checks++;
         if (o.init_cnt != (e.init ? 1 : 0) || o.init_at_tick !== e.init) begin n_fail++;
            $display("FAIL armed_start map_init f%0d: got %0d pulses required %0d", fr, o.init_cnt, e.init); end
         n_checks++;
         if (o.glitch != 0 || o.bad_ra != 0) begin n_fail++;
            $display("FAIL armed_start off_tick f%0d: got %0d/%0d required 0/0", fr, o.glitch, o.bad_ra); end
      end
   endtask

   task automatic test_p1_hit_win_hold;
      exp_t e;
      obs_t o;
      int fr = 0;
      frame(1'b0,  3, -1, PLAYER2_WIN, 1'b0);
      frame(1'b1, -1,  4, PLAYER2_WIN, 1'b0);
      frame(1'b0,  6, -1, PLAYER2_WIN, 1'b0);
      frame(1'b0, -1, -1, START,       1'b0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); fr++;
         n_checks++;
         if (o.mode !== e.mode) begin n_fail++;
            $display("FAIL p1_hit mode f%0d: got %s required %s", fr, o.mode.name(), e.mode.name()); end
         n_checks++;
         if (o.init_cnt != (e.init ? 1 : 0) || o.init_at_tick !== e.init) begin n_fail++;
            $display("FAIL p1_hit map_init f%0d: got %0d pulses required %0d", fr, o.init_cnt, e.init); end
         n_checks++;
         if (o.glitch != 0 || o.bad_ra != 0) begin n_fail++;
            $display("FAIL p1_hit off_tick f%0d: got %0d/%0d required 0/0", fr, o.glitch, o.bad_ra); end
      end
   endtask

   task automatic test_coincident_p2_hit;
      exp_t e;
      obs_t o;
      int fr = 0;
      frame(1'b0, -1, -1, START,       1'b0);
      frame(1'b1, -1, -1, START,       1'b0);
      frame(1'b1, -1, -1, GAME,        1'b1);
      frame(1'b0, -1, 15, PLAYER1_WIN, 1'b0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); fr++;
         n_checks++;
         if (o.mode !== e.mode) begin n_fail++;
            $display("FAIL coincident mode f%0d: got %s required %s", fr, o.mode.name(), e.mode.name()); end
         n_checks++;
         if (o.init_cnt != (e.init ? 1 : 0) || o.init_at_tick !== e.init) begin n_fail++;
            $display("FAIL coincident map_init f%0d: got %0d pulses required %0d", fr, o.init_cnt, e.init); end
         n_checks++;
         if (o.glitch != 0 || o.bad_ra != 0) begin n_fail++;
            $display("FAIL coincident off_tick f%0d: got %0d/%0d required 0/0", fr, o.glitch, o.bad_ra); end
      end
   endtask

   task automatic test_held_button;
      exp_t e;
      obs_t o;
      int fr = 0;
      frame(1'b1, -1, -1, PLAYER1_WIN, 1'b0);
      frame(1'b1, -1, -1, PLAYER1_WIN, 1'b0);
      frame(1'b1, -1, -1, START,       1'b0);
      for (int i = 0; i < 5; i++) frame(1'b1, -1, -1, START, 1'b0);
      frame(1'b0, -1, -1, START, 1'b0);
      frame(1'b1, -1, -1, START, 1'b0);
      frame(1'b1, -1, -1, GAME,  1'b1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); fr++;
         n_checks++;
         if (o.mode !== e.mode) begin n_fail++;
            $display("FAIL held_btn mode f%0d: got %s required %s", fr, o.mode.name(), e.mode.name()); end
         n_checks++;
         if (o.init_cnt != (e.init ? 1 : 0) || o.init_at_tick !== e.init) begin n_fail++;
            $display("FAIL held_btn map_init f%0d: got %0d pulses required %0d", fr, o.init_cnt, e.init); end
         n_checks++;
         if (o.glitch != 0 || o.bad_ra != 0) begin n_fail++;
            $display("FAIL held_btn off_tick f%0d: got %0d/%0d required 0/0", fr, o.glitch, o.bad_ra); end
      end
   endtask

   task automatic test_draw;
      exp_t e;
      obs_t o;
      int fr = 0;
      frame(1'b0,  2, 10, START, 1'b0);
      frame(1'b0, -1, -1, START, 1'b0);
      frame(1'b1, -1, -1, START, 1'b0);
      frame(1'b1, -1, -1, GAME,  1'b1);
      frame(1'b0, -1, -1, GAME,  1'b0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); fr++;
         n_checks++;
         if (o.mode !== e.mode) begin n_fail++;
            $display("FAIL draw mode f%0d: got %s required %s", fr, o.mode.name(), e.mode.name()); end
         n_checks++;
         if (o.init_cnt != (e.init ? 1 : 0) || o.init_at_tick !== e.init) begin n_fail++;
            $display("FAIL draw map_init f%0d: got %0d pulses required %0d", fr, o.init_cnt, e.init); end
         n_checks++;
         if (o.glitch != 0 || o.bad_ra != 0) begin n_fail++;
            $display("FAIL draw off_tick f%0d: got %0d/%0d required 0/0", fr, o.glitch, o.bad_ra); end
      end
   endtask

   task automatic test_reset_mid_game;
      exp_t e;
      obs_t o;
      int fr = 0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (game_mode !== START || round_active !== 1'b0 || map_init !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_game_reset: got mode=%0d ra=%b init=%b required mode=0 ra=0 init=0",
                  game_mode, round_active, map_init);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++;
      if (dut.frame_tick !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_game_no_tick: got %b required 0", dut.frame_tick);
      end
      last_mode = START;
      frame(1'b1, -1, -1, START, 1'b0);
      frame(1'b1, -1, -1, START, 1'b0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); fr++;
         n_checks++;
         if (o.mode !== e.mode) begin n_fail++;
            $display("FAIL post_reset mode f%0d: got %s required %s", fr, o.mode.name(), e.mode.name()); end
         n_checks++;
         if (o.init_cnt != 0 || o.glitch != 0 || o.bad_ra != 0) begin n_fail++;
            $display("FAIL post_reset quiet f%0d: got %0d/%0d/%0d required 0/0/0", fr, o.init_cnt, o.glitch, o.bad_ra); end
      end
   endtask

   initial begin
      test_reset();
      test_armed_start();
      test_p1_hit_win_hold();
      test_coincident_p2_hit();
      test_held_button();
      test_draw();
      test_reset_mid_game();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
